// File: rtl/onewire_rx_assembler_if.sv
// rtl/onewire_rx_assembler_if.sv - bit-level handshake and frame result bundle for onewire_rx_assembler
interface onewire_rx_assembler_if;
   logic        start;
   logic        bit_valid;
   logic        bit_value;
   logic        busy;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        frame_valid;
   logic [15:0] temp_raw;
   logic        crc_ok;

   modport master (
      output start, bit_valid, bit_value,
      input  busy, byte_valid, byte_data, frame_valid, temp_raw, crc_ok
   );

   modport slave (
      input  start, bit_valid, bit_value,
      output busy, byte_valid, byte_data, frame_valid, temp_raw, crc_ok
   );
endinterface

// File: rtl/onewire_rx_assembler.sv
// rtl/onewire_rx_assembler.sv - LSB-first byte/frame assembler for 1-Wire read slots; CRC-8 check built only with ONEWIRE_RX_CRC_EN
module onewire_rx_assembler #(
   parameter int NUM_BYTES    = 9,
   parameter int TEMP_LSB_IDX = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   onewire_rx_assembler_if.slave bus
);

   localparam logic [3:0] LSB_IDX  = 4'(TEMP_LSB_IDX);
   localparam logic [3:0] MSB_IDX  = 4'(TEMP_LSB_IDX + 1);
   localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t      state_q;
   logic [2:0]  bit_cnt_q;
   logic [3:0]  byte_cnt_q;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  temp_lsb_q, temp_lsb_d;
   logic [7:0]  temp_msb_q, temp_msb_d;
   logic        busy_q;
   logic        byte_valid_q;
   logic [7:0]  byte_data_q;
   logic        frame_valid_q;
   logic [15:0] temp_raw_q;
   logic        crc_ok_q, crc_ok_d;
   logic        take_bit, byte_done, frame_done;
`ifdef ONEWIRE_RX_CRC_EN
   logic [7:0]  crc_q, crc_d;
   logic        crc_fb;
`endif

   // Next-state datapath values for the bit being accepted this cycle
   always_comb begin
      // start has priority: a bit arriving with start belongs to no frame
      take_bit   = (state_q == COLLECT) && bus.bit_valid && !bus.start;
      byte_done  = take_bit && (bit_cnt_q == 3'd7);
      frame_done = byte_done && (byte_cnt_q == LAST_IDX);
      shift_d    = {bus.bit_value, shift_q[7:1]};
      temp_lsb_d = (byte_done && byte_cnt_q == LSB_IDX) ? shift_d : temp_lsb_q;
      temp_msb_d = (byte_done && byte_cnt_q == MSB_IDX) ? shift_d : temp_msb_q;
`ifdef ONEWIRE_RX_CRC_EN
      crc_fb     = crc_q[0] ^ bus.bit_value;
      crc_d      = (crc_q >> 1) ^ (crc_fb ? 8'h8C : 8'h00);
      // a frame whose trailing CRC byte matches leaves the register at zero
      crc_ok_d   = (crc_d == 8'h00);
`else
      crc_ok_d   = 1'b1;
`endif
   end

   // Frame FSM with registered outputs; byte/frame results appear one cycle after the closing bit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         bit_cnt_q     <= 3'd0;
         byte_cnt_q    <= 4'd0;
         shift_q       <= 8'h00;
         temp_lsb_q    <= 8'h00;
         temp_msb_q    <= 8'h00;
         busy_q        <= 1'b0;
         byte_valid_q  <= 1'b0;
         byte_data_q   <= 8'h00;
         frame_valid_q <= 1'b0;
         temp_raw_q    <= 16'h0000;
         crc_ok_q      <= 1'b0;
`ifdef ONEWIRE_RX_CRC_EN
         crc_q         <= 8'h00;
`endif
      end else begin
         byte_valid_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         if (bus.start) begin
            // arm or re-arm; an aborted frame leaves temp_raw/crc_ok untouched
            state_q    <= COLLECT;
            busy_q     <= 1'b1;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 4'd0;
            shift_q    <= 8'h00;
            temp_lsb_q <= 8'h00;
            temp_msb_q <= 8'h00;
`ifdef ONEWIRE_RX_CRC_EN
            crc_q      <= 8'h00;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= IDLE;
               end
               COLLECT: begin
                  if (take_bit) begin
                     shift_q    <= shift_d;
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     temp_lsb_q <= temp_lsb_d;
                     temp_msb_q <= temp_msb_d;
`ifdef ONEWIRE_RX_CRC_EN
                     crc_q      <= crc_d;
`endif
                     if (byte_done) begin
                        byte_valid_q <= 1'b1;
                        byte_data_q  <= shift_d;
                        byte_cnt_q   <= byte_cnt_q + 4'd1;
                     end
                     if (frame_done) begin
                        state_q       <= DONE;
                        frame_valid_q <= 1'b1;
                        busy_q        <= 1'b0;
                        temp_raw_q    <= {temp_msb_d, temp_lsb_d};
                        crc_ok_q      <= crc_ok_d;
                     end
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.byte_valid  = byte_valid_q;
   assign bus.byte_data   = byte_data_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.temp_raw    = temp_raw_q;
   assign bus.crc_ok      = crc_ok_q;

endmodule

// File: tb/tb_onewire_rx_assembler.sv
// tb/tb_onewire_rx_assembler.sv - directed bench with frame-level reference model for onewire_rx_assembler
module tb_onewire_rx_assembler;

   localparam int NB = 9;
   localparam int TI = 0;

`ifdef ONEWIRE_RX_CRC_EN
   localparam logic BAD_CRC_OK = 1'b0;
`else
   localparam logic BAD_CRC_OK = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   onewire_rx_assembler_if ifc ();

   onewire_rx_assembler #(.NUM_BYTES(NB), .TEMP_LSB_IDX(TI)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_busy, m_bv, m_fv, m_crc;
   logic [7:0]  m_bd;
   logic [15:0] m_temp;
   logic [7:0]  fb [16];
   bit          collecting = 1'b0;
   int          nbits = 0;

   // Byte-at-a-time Dallas/Maxim CRC over the received frame
   function automatic logic [7:0] frame_crc();
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < NB; k++) begin
         c = c ^ fb[k];
         for (int j = 0; j < 8; j++)
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
      end
      return c;
   endfunction

   // Expected outputs after each edge, derived from the frame-level rules
   always @(posedge clk) begin
      m_bv = 1'b0;
      m_fv = 1'b0;
      if (!rst_n) begin
         collecting = 1'b0;
         nbits  = 0;
         m_busy = 1'b0;
         m_bd   = 8'h00;
         m_temp = 16'h0000;
         m_crc  = 1'b0;
      end else if (ifc.start) begin
         collecting = 1'b1;
         nbits  = 0;
         m_busy = 1'b1;
      end else if (collecting && ifc.bit_valid) begin
         fb[nbits / 8][nbits % 8] = ifc.bit_value;
         nbits++;
         if (nbits % 8 == 0) begin
            m_bv = 1'b1;
            m_bd = fb[nbits / 8 - 1];
            if (nbits == NB * 8) begin
               m_fv   = 1'b1;
               m_busy = 1'b0;
               collecting = 1'b0;
               m_temp = {fb[TI + 1], fb[TI]};
`ifdef ONEWIRE_RX_CRC_EN
               m_crc  = (frame_crc() == 8'h00);
`else
               m_crc  = 1'b1;
`endif
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;
   int n_bv = 0;
   int n_fv = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",        32'(ifc.busy),        32'(m_busy));
         check("byte_valid",  32'(ifc.byte_valid),  32'(m_bv));
         check("byte_data",   32'(ifc.byte_data),   32'(m_bd));
         check("frame_valid", 32'(ifc.frame_valid), 32'(m_fv));
         check("temp_raw",    32'(ifc.temp_raw),    32'(m_temp));
         check("crc_ok",      32'(ifc.crc_ok),      32'(m_crc));
         if (ifc.byte_valid === 1'b1)  n_bv++;
         if (ifc.frame_valid === 1'b1) n_fv++;
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] good [NB] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int gap);
      ifc.bit_valid = 1'b1;
      ifc.bit_value = b;
      @(negedge clk);
      ifc.bit_valid = 1'b0;
      ifc.bit_value = 1'b0;
      if (gap > 1) idle(gap - 1);
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic send_frame(input int gap, input logic [7:0] last);
      logic [7:0] v;
      for (int k = 0; k < NB; k++) begin
         v = (k == NB - 1) ? last : good[k];
         for (int j = 0; j < 8; j++) send_bit(v[j], gap);
      end
   endtask

   int cyc;

   initial begin
      ifc.start     = 1'b0;
      ifc.bit_valid = 1'b0;
      ifc.bit_value = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      idle(2);
      check("reset_busy", 32'(ifc.busy), 32'd0);
      check("reset_temp", 32'(ifc.temp_raw), 32'h0);
      check("reset_crc",  32'(ifc.crc_ok), 32'd0);
      rst_n = 1'b1;
      idle(1);

      // 1: valid frame, one bit every 4 cycles
      n_bv = 0; n_fv = 0;
      pulse_start();
      check("s1_busy_after_start", 32'(ifc.busy), 32'd1);
      send_frame(4, 8'h1C);
      idle(2);
      check("s1_bytes",  32'(n_bv), 32'd9);
      check("s1_frames", 32'(n_fv), 32'd1);
      check("s1_temp",   32'(ifc.temp_raw), 32'h0550);
      check("s1_crc",    32'(ifc.crc_ok), 32'd1);
      check("s1_lastbyte", 32'(ifc.byte_data), 32'h1C);

      // 2: corrupted CRC byte
      n_fv = 0;
      pulse_start();
      send_frame(2, 8'h1D);
      idle(2);
      check("s2_frames", 32'(n_fv), 32'd1);
      check("s2_temp",   32'(ifc.temp_raw), 32'h0550);
      check("s2_crc",    32'(ifc.crc_ok), 32'(BAD_CRC_OK));

      // 3: abort after 20 bits, restart, full frame
      n_bv = 0; n_fv = 0;
      pulse_start();
      for (int i = 0; i < 20; i++) send_bit(good[i / 8][i % 8], 2);
      check("s3_abort_busy", 32'(ifc.busy), 32'd1);
      pulse_start();
      check("s3_abort_crc_hold", 32'(ifc.crc_ok), 32'(BAD_CRC_OK));
      send_frame(3, 8'h1C);
      idle(2);
      check("s3_frames", 32'(n_fv), 32'd1);
      check("s3_bytes",  32'(n_bv), 32'd11);
      check("s3_temp",   32'(ifc.temp_raw), 32'h0550);
      check("s3_crc",    32'(ifc.crc_ok), 32'd1);

      // 4: bits in IDLE, then a bit coincident with start
      n_bv = 0; n_fv = 0;
      for (int i = 0; i < 10; i++) send_bit(1'b1, 1);
      check("s4_idle_bytes", 32'(n_bv), 32'd0);
      ifc.start = 1'b1; ifc.bit_valid = 1'b1; ifc.bit_value = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0; ifc.bit_valid = 1'b0; ifc.bit_value = 1'b0;
      send_frame(2, 8'h1C);
      idle(2);
      check("s4_frames", 32'(n_fv), 32'd1);
      check("s4_bytes",  32'(n_bv), 32'd9);
      check("s4_temp",   32'(ifc.temp_raw), 32'h0550);
      check("s4_crc",    32'(ifc.crc_ok), 32'd1);

      // 5: reset mid-frame after 40 bits
      n_fv = 0;
      pulse_start();
      for (int i = 0; i < 40; i++) send_bit(good[i / 8][i % 8], 1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("s5_rst_busy", 32'(ifc.busy), 32'd0);
      check("s5_rst_temp", 32'(ifc.temp_raw), 32'h0);
      check("s5_rst_crc",  32'(ifc.crc_ok), 32'd0);
      check("s5_rst_data", 32'(ifc.byte_data), 32'h0);
      pulse_start();
      send_frame(2, 8'h1C);
      idle(2);
      check("s5_frames", 32'(n_fv), 32'd1);
      check("s5_temp",   32'(ifc.temp_raw), 32'h0550);

      // 6: back-to-back bits, frame_valid at cycle 73
      n_bv = 0; n_fv = 0;
      pulse_start();
      send_frame(1, 8'h1C);
      check("s6_fv_cycle73", 32'(ifc.frame_valid), 32'd1);
      check("s6_busy_low",   32'(ifc.busy), 32'd0);
      cyc = 0;
      idle(2);
      check("s6_bytes",  32'(n_bv), 32'd9);
      check("s6_frames", 32'(n_fv), 32'd1);
      check("s6_crc",    32'(ifc.crc_ok), 32'd1);
      check("s6_temp",   32'(ifc.temp_raw), 32'h0550);

      // bit in DONE/IDLE after frame is ignored
      n_bv = 0;
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1);
      idle(2);
      check("post_idle_bytes", 32'(n_bv), 32'd0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
